mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4, meaning consecutive denied fetch cycles before fetch is forced to win.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port if_req  input  1  instruction-fetch request, held until granted.
REQ-005 SHALL have port if_addr  input  32  fetch byte address.
REQ-006 SHALL have port if_gnt  output  1  fetch accepted this cycle.
REQ-007 SHALL have port if_rvalid  output  1  fetch data valid.
REQ-008 SHALL have port if_rdata  output  32  fetch data.
REQ-009 SHALL have port d_req  input  1  data request (load or store), held until granted.
REQ-010 SHALL have port d_we  input  1  store when 1, load when 0.
REQ-011 SHALL have port d_addr  input  32  data byte address.
REQ-012 SHALL have port d_wdata  input  32  store data.
REQ-013 SHALL have port d_gnt  output  1  data access accepted this cycle.
REQ-014 SHALL have port d_rvalid  output  1  load data valid or store acknowledged.
REQ-015 SHALL have port d_rdata  output  32  load data.
REQ-016 SHALL have port mem_en  output  1  single-port memory access enable.
REQ-017 SHALL have port mem_we  output  1  memory write enable.
REQ-018 SHALL have port mem_addr  output  32  memory address.
REQ-019 SHALL have port mem_wdata  output  32  memory write data.
REQ-020 SHALL have port mem_rdata  input  32  memory read data, valid one cycle after mem_en.
REQ-021 SHALL have port stall  output  1  equals if_req & ~if_gnt; freezes PC in the core.

Function
REQ-022 SHALL grant at most one requester per cycle; if_gnt and d_gnt never both 1.
REQ-023 SHALL grant combinationally in the cycle the request is present; mem_en=1 exactly when a grant is issued.
REQ-024 SHALL give data priority over fetch, except that fetch wins when the starvation counter equals STARVE_MAX.
REQ-025 SHALL drive mem_addr/mem_wdata/mem_we from the granted port; mem_we=d_we only for a data grant, else 0.
REQ-026 SHALL respond exactly one cycle after grant: rvalid of the granted port pulses 1 for one cycle and rdata=mem_rdata.
REQ-027 SHALL drive *_rdata to 0 when the corresponding rvalid is 0.
REQ-028 SHALL pulse d_rvalid for stores as an acknowledge, with d_rdata=0.
REQ-029 SHALL sustain one grant per cycle back-to-back (fully pipelined, no bubble between accesses).
REQ-030 SHALL track the outstanding response owner with FSM states RESP_NONE, RESP_IF, RESP_D; next state = owner of this cycle's grant, else RESP_NONE.
REQ-031 SHALL increment the starvation counter each cycle if_req=1 and if_gnt=0, saturating at STARVE_MAX; clear it on if_gnt or when if_req=0.
REQ-032 SHALL, on simultaneous requests with counter below STARVE_MAX, grant data and hold fetch (stall=1).
REQ-033 SHALL treat requests with addresses differing only in bits [1:0] identically; alignment is the requester's responsibility.

Reset
REQ-034 SHALL, while reset=0, force FSM to RESP_NONE, counter to 0, all outputs to 0 except stall, which follows REQ-021 with if_gnt=0.
REQ-035 SHALL discard any outstanding response on reset assertion; no rvalid pulse in the cycle after release.
REQ-036 SHALL issue no grant in any cycle with reset=0.

Structure
REQ-037 SHALL take the response-owner enum (RESP_NONE, RESP_IF, RESP_D) and the STARVE_MAX default from a shared package mem_arb_pkg.
REQ-038 SHALL implement the saturating starvation counter as sub-module arb_starve_ctr; all other logic is flat.

Verification
REQ-039 SHALL cover: if_req=1, if_addr=0x0000_0010, mem_rdata=0x0051_3023 next cycle -> if_gnt=1, mem_en=1, if_rvalid=1 next cycle, if_rdata=0x0051_3023.
REQ-040 SHALL cover: d_req=1, d_we=1, d_addr=0x64, d_wdata=0xDEAD_BEEF with if_req=1 -> d_gnt=1, mem_we=1, mem_addr=0x64, stall=1, d_rvalid=1 next cycle.
REQ-041 SHALL cover: d_req and if_req held high 6 cycles, STARVE_MAX=4 -> d_gnt cycles 0-3, if_gnt cycle 4, d_gnt cycle 5.
REQ-042 SHALL cover: alternating fetch 0x0,0x4 and load 0x100 back-to-back -> one grant per cycle, responses routed to the correct port with no bubble.
REQ-043 SHALL cover: reset driven low the cycle after a load grant -> d_rvalid stays 0, all outputs 0, counter 0 after release.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the fetch/data single-port memory arbiter.
package mem_arb_pkg;

    localparam int unsigned STARVE_MAX_DEFAULT = 4;
    localparam int unsigned ADDR_W             = 32;
    localparam int unsigned DATA_W             = 32;

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_IF   = 2'd1,
        RESP_D    = 2'd2
    } resp_owner_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    // Counter width able to hold 0..max, never narrower than one bit.
    function automatic int unsigned ctr_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive cycles the fetch port was held off.
module arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic starved,
    input  logic clear,
    output logic at_max_c
);

    localparam int unsigned CW = ctr_width(STARVE_MAX);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (starved && (cnt_q != CW'(STARVE_MAX))) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign at_max_c = (cnt_q == CW'(STARVE_MAX));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and data accesses onto one single-port memory,
// data first unless fetch has been starved for STARVE_MAX cycles.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall
);

    logic        starve_at_max_c;
    logic        d_win;
    logic        if_win;
    mem_req_t    sel;
    resp_owner_e state_q;
    resp_owner_e state_d;
    logic        store_q;

    // Grant decision: nothing while in reset, data first unless fetch is starved.
    assign d_win  = reset & d_req & ~(if_req & starve_at_max_c);
    assign if_win = reset & if_req & ~d_win;

    assign if_gnt = if_win;
    assign d_gnt  = d_win;
    assign mem_en = if_win | d_win;
    assign stall  = if_req & ~if_win;

    always_comb begin
        sel = '0;
        if (d_win) begin
            sel.we    = d_we;
            sel.addr  = d_addr;
            sel.wdata = d_wdata;
        end else if (if_win) begin
            sel.addr  = if_addr;
        end
    end

    assign mem_we    = sel.we;
    assign mem_addr  = sel.addr;
    assign mem_wdata = sel.wdata;

    arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk      (clk),
        .reset    (reset),
        .starved  (if_req & ~if_win),
        .clear    (~if_req | if_win),
        .at_max_c (starve_at_max_c)
    );

    // Response owner: whoever was granted last cycle gets this cycle's read data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RESP_NONE;
            store_q <= 1'b0;
        end else begin
            state_q <= state_d;
            store_q <= d_win & d_we;
        end
    end

    always_comb begin
        state_d = RESP_NONE;
        if (d_win) begin
            state_d = RESP_D;
        end else if (if_win) begin
            state_d = RESP_IF;
        end
    end

    // Stores are acknowledged with zero data.
    always_comb begin
        if_rvalid = 1'b0;
        if_rdata  = '0;
        d_rvalid  = 1'b0;
        d_rdata   = '0;
        case (state_q)
            RESP_IF: begin
                if_rvalid = 1'b1;
                if_rdata  = mem_rdata;
            end
            RESP_D: begin
                d_rvalid = 1'b1;
                d_rdata  = store_q ? '0 : mem_rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic
// against a cycle-level arbitration model.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int unsigned SMAX = 4;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        stall;

    int checks = 0;
    int errors = 0;

    // Model: starvation count, owner of the pending response (0 none, 1 fetch, 2 data).
    int m_starve = 0;
    int m_pend   = 0;
    bit m_pend_st = 1'b0;

    mem_arbiter #(.STARVE_MAX(SMAX)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stall(stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int model_grant();
        if (!reset) return 0;
        if (d_req && !(if_req && m_starve == int'(SMAX))) return 2;
        if (if_req) return 1;
        return 0;
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            m_starve  <= 0;
            m_pend    <= 0;
            m_pend_st <= 1'b0;
        end else begin
            m_pend    <= model_grant();
            m_pend_st <= (model_grant() == 2) && d_we;
            if (model_grant() == 1 || !if_req) m_starve <= 0;
            else if (m_starve < int'(SMAX))    m_starve <= m_starve + 1;
        end
    end

    // Apply one cycle of inputs at the falling edge, then let combinational outputs settle.
    task automatic drive(input bit rst, input bit ir, input logic [31:0] ia,
                         input bit dr, input bit dw, input logic [31:0] da,
                         input logic [31:0] dd, input logic [31:0] mr);
        @(negedge clk);
        reset = rst; if_req = ir; if_addr = ia;
        d_req = dr; d_we = dw; d_addr = da; d_wdata = dd; mem_rdata = mr;
        #2;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b1, 32'h10, 1'b1, 1'b1, 32'h64, 32'hDEADBEEF, 32'hFFFFFFFF);
        checks++;
        if ({if_gnt, d_gnt, mem_en, mem_we, if_rvalid, d_rvalid} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 000000", {if_gnt, d_gnt, mem_en, mem_we, if_rvalid, d_rvalid});
        end
        checks++;
        if ({mem_addr, mem_wdata, if_rdata, d_rdata} !== 128'b0) begin
            errors++;
            $display("FAIL reset_data: addr %h wdata %h ir %h dr %h want 0", mem_addr, mem_wdata, if_rdata, d_rdata);
        end
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL reset_stall: got %b want 1", stall);
        end
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic test_fetch();
        drive(1'b1, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        checks++;
        if ({if_gnt, d_gnt, mem_en, mem_we, stall} !== 5'b10100 || mem_addr !== 32'h10) begin
            errors++;
            $display("FAIL fetch_grant: gnt/dg/en/we/stall %b addr %h want 10100 00000010",
                     {if_gnt, d_gnt, mem_en, mem_we, stall}, mem_addr);
        end
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h00513023);
        checks++;
        if (if_rvalid !== 1'b1 || if_rdata !== 32'h00513023 || d_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL fetch_resp: rvalid %b rdata %h drv %b want 1 00513023 0", if_rvalid, if_rdata, d_rvalid);
        end
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'hAAAA5555);
        checks++;
        if (if_rvalid !== 1'b0 || if_rdata !== 32'h0) begin
            errors++;
            $display("FAIL fetch_idle: rvalid %b rdata %h want 0 0", if_rvalid, if_rdata);
        end
    endtask

    task automatic test_store();
        drive(1'b1, 1'b1, 32'h20, 1'b1, 1'b1, 32'h64, 32'hDEADBEEF, 32'h0);
        checks++;
        if ({d_gnt, if_gnt, mem_en, mem_we, stall} !== 5'b10111 ||
            mem_addr !== 32'h64 || mem_wdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL store_grant: dg/ig/en/we/stall %b addr %h wdata %h want 10111 64 deadbeef",
                     {d_gnt, if_gnt, mem_en, mem_we, stall}, mem_addr, mem_wdata);
        end
        drive(1'b1, 1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0, 32'h12345678);
        checks++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'h0 || if_gnt !== 1'b1 || mem_addr !== 32'h20) begin
            errors++;
            $display("FAIL store_ack: drv %b drd %h ig %b addr %h want 1 0 1 20", d_rvalid, d_rdata, if_gnt, mem_addr);
        end
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0, 32'h0BADF00D);
        checks++;
        if (if_rvalid !== 1'b1 || if_rdata !== 32'h0BADF00D || d_gnt !== 1'b1 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL load_grant: irv %b ird %h dg %b we %b want 1 0badf00d 1 0", if_rvalid, if_rdata, d_gnt, mem_we);
        end
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'hCAFE0001);
        checks++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'hCAFE0001) begin
            errors++;
            $display("FAIL load_resp: drv %b drd %h want 1 cafe0001", d_rvalid, d_rdata);
        end
    endtask

    task automatic test_starve();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        for (int c = 0; c < 6; c++) begin
            logic [2:0] exp;
            drive(1'b1, 1'b1, 32'h40, 1'b1, 1'b0, 32'h80, 32'h0, 32'h0);
            exp = (c == 4) ? 3'b100 : 3'b011;
            checks++;
            if ({if_gnt, d_gnt, stall} !== exp) begin
                errors++;
                $display("FAIL starve_c%0d: ig/dg/stall %b want %b", c, {if_gnt, d_gnt, stall}, exp);
            end
        end
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] faddr [3];
        faddr[0] = 32'h0; faddr[1] = 32'h4; faddr[2] = 32'h0;
        for (int c = 0; c < 7; c++) begin
            bit          is_f;
            logic [31:0] ea;
            is_f = (c % 2 == 0);
            ea   = is_f ? faddr[c / 2] : 32'h100;
            if (c < 6) drive(1'b1, is_f, ea, !is_f, 1'b0, 32'h100, 32'h0, 32'h1000 + 32'(c));
            else       drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h1000 + 32'(c));
            if (c < 6) begin
                checks++;
                if ({if_gnt, d_gnt, mem_en} !== {is_f, !is_f, 1'b1} || mem_addr !== ea) begin
                    errors++;
                    $display("FAIL b2b_grant_c%0d: ig/dg/en %b addr %h want %b %h",
                             c, {if_gnt, d_gnt, mem_en}, mem_addr, {is_f, !is_f, 1'b1}, ea);
                end
            end
            if (c > 0) begin
                bit prev_f;
                prev_f = ((c - 1) % 2 == 0);
                checks++;
                if ({if_rvalid, d_rvalid} !== {prev_f, !prev_f} ||
                    (prev_f ? if_rdata : d_rdata) !== 32'h1000 + 32'(c)) begin
                    errors++;
                    $display("FAIL b2b_resp_c%0d: irv/drv %b ird %h drd %h want %b data %h",
                             c, {if_rvalid, d_rvalid}, if_rdata, d_rdata, {prev_f, !prev_f}, 32'h1000 + 32'(c));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        repeat (3) drive(1'b1, 1'b1, 32'h8, 1'b1, 1'b0, 32'h300, 32'h0, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h77777777);
        checks++;
        if ({if_gnt, d_gnt, mem_en, mem_we, if_rvalid, d_rvalid, stall} !== 7'b0 ||
            {mem_addr, mem_wdata, if_rdata, d_rdata} !== 128'b0) begin
            errors++;
            $display("FAIL midreset_outs: ctrl %b drd %h addr %h want 0",
                     {if_gnt, d_gnt, mem_en, mem_we, if_rvalid, d_rvalid, stall}, d_rdata, mem_addr);
        end
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h77777777);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h55555555);
        checks++;
        if ({if_rvalid, d_rvalid} !== 2'b00 || d_rdata !== 32'h0) begin
            errors++;
            $display("FAIL midreset_release: irv/drv %b drd %h want 00 0", {if_rvalid, d_rvalid}, d_rdata);
        end
        for (int c = 0; c < 5; c++) begin
            logic [1:0] exp;
            drive(1'b1, 1'b1, 32'h8, 1'b1, 1'b0, 32'h300, 32'h0, 32'h0);
            exp = (c == 4) ? 2'b10 : 2'b01;
            checks++;
            if ({if_gnt, d_gnt} !== exp) begin
                errors++;
                $display("FAIL midreset_ctr_c%0d: ig/dg %b want %b", c, {if_gnt, d_gnt}, exp);
            end
        end
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic test_random();
        bit          rst, ir, dr, dw;
        logic [31:0] ia, da, dd, mr;
        int          g;
        ir = 1'b0; dr = 1'b0; dw = 1'b0; ia = '0; da = '0; dd = '0; g = 0;
        for (int c = 0; c < 400; c++) begin
            int          eg;
            logic [31:0] e_addr, e_wdata, e_ird, e_drd;
            bit          e_irv, e_drv;
            if (!ir || g == 1) begin
                ir = ($urandom_range(0, 99) < 60);
                ia = $urandom;
            end
            if (!dr || g == 2) begin
                dr = ($urandom_range(0, 99) < 55);
                dw = $urandom_range(0, 1);
                da = $urandom;
                dd = $urandom;
            end
            rst = ($urandom_range(0, 99) >= 3);
            mr  = $urandom;
            drive(rst, ir, ia, dr, dw, da, dd, mr);
            eg      = model_grant();
            e_addr  = (eg == 2) ? da : (eg == 1) ? ia : 32'h0;
            e_wdata = (eg == 2) ? dd : 32'h0;
            e_irv   = rst && (m_pend == 1);
            e_drv   = rst && (m_pend == 2);
            e_ird   = e_irv ? mr : 32'h0;
            e_drd   = (e_drv && !m_pend_st) ? mr : 32'h0;
            checks++;
            if ({if_gnt, d_gnt, mem_en, mem_we, stall} !==
                {eg == 1, eg == 2, eg != 0, eg == 2 && dw, ir && eg != 1}) begin
                errors++;
                $display("FAIL rand_ctrl_c%0d: ig/dg/en/we/stall %b want %b", c,
                         {if_gnt, d_gnt, mem_en, mem_we, stall},
                         {eg == 1, eg == 2, eg != 0, eg == 2 && dw, ir && eg != 1});
            end
            checks++;
            if (mem_addr !== e_addr || mem_wdata !== e_wdata) begin
                errors++;
                $display("FAIL rand_bus_c%0d: addr %h wdata %h want %h %h", c, mem_addr, mem_wdata, e_addr, e_wdata);
            end
            checks++;
            if ({if_rvalid, d_rvalid} !== {e_irv, e_drv} || if_rdata !== e_ird || d_rdata !== e_drd) begin
                errors++;
                $display("FAIL rand_resp_c%0d: irv/drv %b ird %h drd %h want %b %h %h", c,
                         {if_rvalid, d_rvalid}, if_rdata, d_rdata, {e_irv, e_drv}, e_ird, e_drd);
            end
            g = eg;
        end
    endtask

    initial begin
        reset = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        test_reset();
        test_fetch();
        test_store();
        test_starve();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
